// File: rtl/controlador_ram_dados.sv
// Access controller for the 11x11 data RAM: shares the single RAM port between
// the CPU load/store path (fixed priority) and a row-major, wrapping DMA burst engine.
module controlador_ram_dados #(
  parameter int NUM_LINHAS  = 11,
  parameter int NUM_COLUNAS = 11,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  // CPU load/store path
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_linha,
  input  logic [ADDR_W-1:0] cpu_coluna,
  input  logic [DATA_W-1:0] cpu_dados,
  output logic [DATA_W-1:0] cpu_saida,
  // DMA control
  input  logic              dma_start,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_linha,
  input  logic [ADDR_W-1:0] dma_coluna,
  input  logic [LEN_W-1:0]  dma_len,
  // DMA write stream
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_wvalid,
  output logic              dma_wready,
  // DMA read stream
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  input  logic              dma_rready,
  // DMA status
  output logic              dma_busy,
  output logic              dma_done,
  output logic              dma_erro,
  // RAM port
  output logic [DATA_W-1:0] ram_dados,
  output logic [ADDR_W-1:0] ram_linha,
  output logic [ADDR_W-1:0] ram_coluna,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_saida
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESCRITA = 2'd1,
    LEITURA = 2'd2,
    FIM     = 2'd3
  } estado_t;

  localparam logic [ADDR_W-1:0] TOTAL_LINHAS   = ADDR_W'(NUM_LINHAS);
  localparam logic [ADDR_W-1:0] TOTAL_COLUNAS  = ADDR_W'(NUM_COLUNAS);
  localparam logic [ADDR_W-1:0] ULTIMA_LINHA   = ADDR_W'(NUM_LINHAS - 1);
  localparam logic [ADDR_W-1:0] ULTIMA_COLUNA  = ADDR_W'(NUM_COLUNAS - 1);
  localparam logic [ADDR_W-1:0] UM_ADDR        = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  UM_LEN         = LEN_W'(1);

  estado_t           estado;
  logic [ADDR_W-1:0] linha_atual;
  logic [ADDR_W-1:0] coluna_atual;
  logic [LEN_W-1:0]  restante;

  logic [ADDR_W-1:0] prox_linha;
  logic [ADDR_W-1:0] prox_coluna;
  logic              inicio_invalido;
  logic              leitura_livre;
  logic              aceita_escrita;
  logic              concede_leitura;

  // Row-major advance; the last cell wraps back to (0,0).
  always_comb begin
    prox_linha  = linha_atual;
    prox_coluna = coluna_atual + UM_ADDR;
    if (coluna_atual == ULTIMA_COLUNA) begin
      prox_coluna = '0;
      prox_linha  = (linha_atual == ULTIMA_LINHA) ? '0 : linha_atual + UM_ADDR;
    end
  end

  always_comb begin
    inicio_invalido = (dma_linha >= TOTAL_LINHAS) || (dma_coluna >= TOTAL_COLUNAS);
    leitura_livre   = ~dma_rvalid | dma_rready;
    aceita_escrita  = (estado == ESCRITA) & ~cpu_req & dma_wvalid;
    concede_leitura = (estado == LEITURA) & ~cpu_req & (restante != '0) & leitura_livre;
    dma_wready      = (estado == ESCRITA) & ~cpu_req;
  end

  // RAM port mux: the CPU owns the port whenever it asks for it.
  always_comb begin
    cpu_saida = ram_saida;
    if (cpu_req) begin
      ram_linha  = cpu_linha;
      ram_coluna = cpu_coluna;
      ram_dados  = cpu_dados;
      ram_write  = cpu_write;
    end else begin
      ram_linha  = linha_atual;
      ram_coluna = coluna_atual;
      ram_dados  = dma_wdata;
      ram_write  = aceita_escrita;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      linha_atual  <= '0;
      coluna_atual <= '0;
      restante     <= '0;
      dma_rdata    <= '0;
      dma_rvalid   <= 1'b0;
      dma_busy     <= 1'b0;
      dma_done     <= 1'b0;
      dma_erro     <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      dma_erro <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (dma_start) begin
            dma_busy <= 1'b1;
            if (inicio_invalido) begin
              estado   <= FIM;
              dma_done <= 1'b1;
              dma_erro <= 1'b1;
            end else if (dma_len == '0) begin
              estado   <= FIM;
              dma_done <= 1'b1;
            end else begin
              linha_atual  <= dma_linha;
              coluna_atual <= dma_coluna;
              restante     <= dma_len;
              estado       <= dma_write ? ESCRITA : LEITURA;
            end
          end
        end

        ESCRITA: begin
          if (aceita_escrita) begin
            linha_atual  <= prox_linha;
            coluna_atual <= prox_coluna;
            restante     <= restante - UM_LEN;
            if (restante == UM_LEN) begin
              estado   <= FIM;
              dma_done <= 1'b1;
            end
          end
        end

        LEITURA: begin
          // The output register only refills once its current word is taken.
          if (concede_leitura) begin
            dma_rdata    <= ram_saida;
            dma_rvalid   <= 1'b1;
            linha_atual  <= prox_linha;
            coluna_atual <= prox_coluna;
            restante     <= restante - UM_LEN;
          end else if (dma_rready) begin
            dma_rvalid <= 1'b0;
          end
          if ((restante == '0) && leitura_livre) begin
            estado   <= FIM;
            dma_done <= 1'b1;
          end
        end

        FIM: begin
          estado   <= OCIOSO;
          dma_busy <= 1'b0;
        end

        default: begin
          estado   <= OCIOSO;
          dma_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_ram_dados.sv
// Self-checking bench for controlador_ram_dados: behavioural RAM, directed bursts
// from the test plan, then randomized bursts against an address-index model.
module tb_controlador_ram_dados;

  localparam int NL = 11;
  localparam int NC = 11;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int NW = NL * NC;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_write;
  logic [AW-1:0] cpu_linha, cpu_coluna;
  logic [DW-1:0] cpu_dados, cpu_saida;
  logic          dma_start, dma_write;
  logic [AW-1:0] dma_linha, dma_coluna;
  logic [LW-1:0] dma_len;
  logic [DW-1:0] dma_wdata;
  logic          dma_wvalid, dma_wready;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid, dma_rready;
  logic          dma_busy, dma_done, dma_erro;
  logic [DW-1:0] ram_dados, ram_saida;
  logic [AW-1:0] ram_linha, ram_coluna;
  logic          ram_write;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];

  always #5 clock = ~clock;

  controlador_ram_dados #(
    .NUM_LINHAS (NL),
    .NUM_COLUNAS(NC),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LEN_W      (LW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_linha  (cpu_linha),
    .cpu_coluna (cpu_coluna),
    .cpu_dados  (cpu_dados),
    .cpu_saida  (cpu_saida),
    .dma_start  (dma_start),
    .dma_write  (dma_write),
    .dma_linha  (dma_linha),
    .dma_coluna (dma_coluna),
    .dma_len    (dma_len),
    .dma_wdata  (dma_wdata),
    .dma_wvalid (dma_wvalid),
    .dma_wready (dma_wready),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid),
    .dma_rready (dma_rready),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done),
    .dma_erro   (dma_erro),
    .ram_dados  (ram_dados),
    .ram_linha  (ram_linha),
    .ram_coluna (ram_coluna),
    .ram_write  (ram_write),
    .ram_saida  (ram_saida)
  );

  // Behavioural RAM: asynchronous read, write at the rising edge.
  logic ram_ok;
  int   ram_idx;
  always_comb begin
    ram_ok  = (int'(ram_linha) < NL) && (int'(ram_coluna) < NC);
    ram_idx = ram_ok ? (int'(ram_linha) * NC + int'(ram_coluna)) : 0;
  end
  assign ram_saida = ram_ok ? mem[ram_idx] : '0;
  always @(posedge clock) if (ram_write && ram_ok) mem[ram_idx] <= ram_dados;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_write = 0; cpu_linha = '0; cpu_coluna = '0; cpu_dados = '0;
    dma_start = 0; dma_write = 0; dma_linha = '0; dma_coluna = '0; dma_len = '0;
    dma_wdata = '0; dma_wvalid = 0; dma_rready = 0;
  endtask

  // Word k of a burst starting at (l,c), as a flat row-major index modulo the RAM size.
  function automatic int idx_of(input int l, input int c, input int k);
    return (l * NC + c + k) % NW;
  endfunction

  task automatic mem_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic finish_burst(input string tag, input bit fin, input int got, input int want);
    idle_inputs();
    #1;
    if (!fin) chk({tag, "_timeout"}, got, want);
    else begin
      chk({tag, "_done"}, dma_done, 1);
      chk({tag, "_erro"}, dma_erro, 0);
      chk({tag, "_busy_fim"}, dma_busy, 1);
      chk({tag, "_rvalid_fim"}, dma_rvalid, 0);
    end
    tick();
    #1;
    chk({tag, "_done_pulse"}, dma_done, 0);
    chk({tag, "_busy_idle"}, dma_busy, 0);
  endtask

  task automatic run_write(input int l, input int c, input int len, input bit rnd);
    int k = 0;
    int a, cidx;
    bit fin = 0;
    logic [2*AW-1:0] got, want;
    dma_start = 1; dma_write = 1; dma_linha = AW'(l); dma_coluna = AW'(c); dma_len = LW'(len);
    #1;
    chk("wr_busy_before", dma_busy, 0);
    tick();
    dma_start = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      cpu_req    = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      dma_wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      dma_start  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      dma_write  = 1'($urandom_range(0, 1));
      dma_linha  = AW'($urandom_range(0, 15));
      cpu_write  = 1'($urandom_range(0, 1));
      cidx       = $urandom_range(0, 1) ? idx_of(l, c, k) : $urandom_range(0, NW - 1);
      cpu_linha  = AW'(cidx / NC);
      cpu_coluna = AW'(cidx % NC);
      cpu_dados  = $urandom;
      dma_wdata  = $urandom;
      #1;
      chk("wr_wready", dma_wready, !cpu_req);
      chk("wr_ram_write", ram_write, cpu_req ? cpu_write : dma_wvalid);
      chk("wr_done_early", dma_done, 0);
      chk("wr_busy", dma_busy, 1);
      if (cpu_req && !cpu_write) chk("wr_cpu_load", cpu_saida, ref_mem[cidx]);
      if (cpu_req && cpu_write) ref_mem[cidx] = cpu_dados;
      if (!cpu_req && dma_wvalid) begin
        a    = idx_of(l, c, k);
        got  = {ram_linha, ram_coluna};
        want = {AW'(a / NC), AW'(a % NC)};
        chk("wr_addr", got, want);
        ref_mem[a] = dma_wdata;
        k++;
      end
      fin = (k == len);
      tick();
    end
    finish_burst("wr", fin, k, len);
    mem_compare("wr_mem");
  endtask

  task automatic run_read(input int l, input int c, input int len, input bit rnd,
                          input logic [31:0] cpu_pat, input logic [31:0] rr_pat);
    int  issued = 0, consumed = 0, ci;
    bit  held = 0, fin = 0, fetch;
    dma_start = 1; dma_write = 0; dma_linha = AW'(l); dma_coluna = AW'(c); dma_len = LW'(len);
    #1;
    chk("rd_busy_before", dma_busy, 0);
    tick();
    dma_start = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (rnd) begin
        cpu_req    = ($urandom_range(0, 3) == 0);
        dma_rready = ($urandom_range(0, 2) != 0);
        dma_start  = 1'($urandom_range(0, 1));
        dma_write  = 1'($urandom_range(0, 1));
      end else begin
        cpu_req    = (cyc < 32) ? cpu_pat[cyc] : 1'b0;
        dma_rready = (cyc < 32) ? rr_pat[cyc] : 1'b1;
      end
      cpu_write  = 0;
      ci         = $urandom_range(0, NW - 1);
      cpu_linha  = AW'(ci / NC);
      cpu_coluna = AW'(ci % NC);
      #1;
      chk("rd_done_early", dma_done, 0);
      chk("rd_busy", dma_busy, 1);
      chk("rd_rvalid", dma_rvalid, held);
      chk("rd_ram_write", ram_write, 0);
      if (held) chk("rd_data", dma_rdata, ref_mem[idx_of(l, c, consumed)]);
      if (cpu_req) chk("rd_cpu_load", cpu_saida, ref_mem[ci]);
      fin   = (issued == len) && (!held || dma_rready);
      fetch = !cpu_req && (issued < len) && (!held || dma_rready);
      if (held && dma_rready) consumed++;
      held = fetch || (held && !dma_rready);
      if (fetch) issued++;
      tick();
    end
    finish_burst("rd", fin, consumed, len);
  endtask

  task automatic run_start_only(input int l, input int c, input int len, input bit exp_err);
    dma_start = 1; dma_write = 1; dma_linha = AW'(l); dma_coluna = AW'(c); dma_len = LW'(len);
    dma_wvalid = 1; dma_wdata = $urandom;
    tick();
    idle_inputs();
    #1;
    chk("st_done", dma_done, 1);
    chk("st_erro", dma_erro, exp_err);
    chk("st_busy", dma_busy, 1);
    chk("st_ram_write", ram_write, 0);
    tick();
    #1;
    chk("st_done_pulse", dma_done, 0);
    chk("st_erro_pulse", dma_erro, 0);
    chk("st_busy_idle", dma_busy, 0);
    mem_compare("st_mem");
  endtask

  initial begin
    int a;
    idle_inputs();
    reset = 1;
    repeat (2) tick();
    chk("rst_busy", dma_busy, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_erro", dma_erro, 0);
    chk("rst_rvalid", dma_rvalid, 0);
    chk("rst_rdata", dma_rdata, 0);
    chk("rst_wready", dma_wready, 0);
    chk("rst_ram_write", ram_write, 0);
    reset = 0;
    tick();

    // Fill the RAM through the CPU store path.
    for (int i = 0; i < NW; i++) begin
      cpu_req = 1; cpu_write = 1;
      cpu_linha = AW'(i / NC); cpu_coluna = AW'(i % NC); cpu_dados = $urandom;
      ref_mem[i] = cpu_dados;
      #1;
      chk("pre_ram_write", ram_write, 1);
      tick();
    end
    idle_inputs();
    #1;
    mem_compare("pre_mem");

    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, NW - 1);
      cpu_req = 1; cpu_write = 0; cpu_linha = AW'(a / NC); cpu_coluna = AW'(a % NC);
      #1;
      chk("cpu_load", cpu_saida, ref_mem[a]);
      chk("cpu_load_nowrite", ram_write, 0);
      tick();
    end
    idle_inputs();

    run_write(0, 9, 4, 0);
    run_read(10, 10, 2, 0, 32'h0, 32'hFFFF_FFFF);
    run_read(4, 5, 3, 0, 32'h0000_0006, 32'hFFFF_FFFF);
    run_read(2, 3, 3, 0, 32'h0, 32'hFFFF_FFF9);
    run_start_only(11, 0, 5, 1);
    run_start_only(0, 11, 5, 1);
    run_start_only(3, 3, 0, 0);

    for (int i = 0; i < 6; i++) begin
      run_write($urandom_range(0, NL - 1), $urandom_range(0, NC - 1), $urandom_range(1, 40), 1);
      run_read($urandom_range(0, NL - 1), $urandom_range(0, NC - 1), $urandom_range(1, 40), 1,
               32'h0, 32'h0);
    end
    run_write(5, 5, 130, 1);
    run_read(7, 2, 125, 1, 32'h0, 32'h0);

    // Reset during the second beat of a 5-beat write: only beat 1 lands.
    dma_start = 1; dma_write = 1; dma_linha = 3; dma_coluna = 4; dma_len = 5;
    tick();
    dma_start = 0; dma_wvalid = 1; dma_wdata = $urandom;
    ref_mem[idx_of(3, 4, 0)] = dma_wdata;
    #1;
    chk("abort_beat1_write", ram_write, 1);
    tick();
    dma_wdata = $urandom;
    #1;
    reset = 1;
    #1;
    chk("abort_wready", dma_wready, 0);
    chk("abort_ram_write", ram_write, 0);
    chk("abort_busy", dma_busy, 0);
    chk("abort_done", dma_done, 0);
    chk("abort_rvalid", dma_rvalid, 0);
    chk("abort_rdata", dma_rdata, 0);
    tick();
    reset = 0;
    idle_inputs();
    tick();
    #1;
    chk("abort_idle_busy", dma_busy, 0);
    mem_compare("abort_mem");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_ram_dados.md
# controlador_ram_dados

Access controller for the 11×11 word data RAM.
- Shares the RAM's single port between the CPU load/store path and a DMA burst engine, with fixed CPU priority.
- Sequences DMA bursts in row-major order with row/column wrap-around.
- Sits between the CPU datapath, the I/O DMA stream and the data RAM; it is the only driver of the RAM's address, data and write inputs.

## Interface
Parameters:
- NUM_LINHAS, 11, number of RAM rows
- NUM_COLUNAS, 11, number of RAM columns
- ADDR_W, 11, row/column address width
- DATA_W, 32, word width
- LEN_W, 8, burst-length width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access this cycle
- cpu_write  in  1  1 = store, 0 = load
- cpu_linha, cpu_coluna  in  ADDR_W  CPU row/column
- cpu_dados  in  DATA_W  store data
- cpu_saida  out  DATA_W  load data (combinational from ram_saida)
- dma_start  in  1  start pulse, sampled only in OCIOSO
- dma_write  in  1  1 = stream→RAM, 0 = RAM→stream
- dma_linha, dma_coluna  in  ADDR_W  burst start address
- dma_len  in  LEN_W  word count
- dma_wdata  in  DATA_W  write-stream data
- dma_wvalid  in  1  write-stream valid
- dma_wready  out  1  write beat accepted
- dma_rdata  out  DATA_W  read-stream data (registered)
- dma_rvalid  out  1  read-stream valid
- dma_rready  in  1  read-stream consumer ready
- dma_busy  out  1  burst in progress
- dma_done  out  1  one-cycle completion pulse
- dma_erro  out  1  one-cycle error pulse, coincident with dma_done
- ram_dados  out  DATA_W  to RAM dados
- ram_linha, ram_coluna  out  ADDR_W  to RAM address
- ram_write  out  1  to RAM write
- ram_saida  in  DATA_W  from RAM saida

## Operation
- **States:** OCIOSO, ESCRITA, LEITURA, FIM. Reset → OCIOSO.
- **Registered state:** linha_atual, coluna_atual, restante (LEN_W).

**Arbitration:**
- cpu_req=1 always wins. RAM ports are driven combinationally from the CPU inputs, and the DMA gets no slot that cycle.
- With cpu_req=0 the DMA address (linha_atual, coluna_atual) is driven. ram_write=1 only on an accepted DMA write beat, else 0.

**Start (OCIOSO, dma_start=1):**
- If dma_linha≥NUM_LINHAS or dma_coluna≥NUM_COLUNAS: go to FIM with the error flag set. No RAM access.
- Else, if dma_len=0: go to FIM with no error.
- Else: load the address and restante=dma_len, and go to ESCRITA (dma_write=1) or LEITURA (dma_write=0).
- dma_start outside OCIOSO is ignored.

**ESCRITA:**
- dma_wready = ~cpu_req.
- A beat is accepted when dma_wvalid & dma_wready. The RAM is written with dma_wdata the same cycle, the address advances and restante decrements.
- When the last beat is accepted → FIM.

**LEITURA:**
- grant = ~cpu_req & (restante≠0) & (~dma_rvalid | dma_rready).
- On grant: dma_rdata←ram_saida, dma_rvalid←1, the address advances, restante decrements.
- On dma_rready without grant: dma_rvalid←0.
- When restante=0 and (~dma_rvalid | dma_rready) → FIM.

**FIM:** dma_done=1, dma_erro=error flag, for exactly one cycle, then → OCIOSO.

**Address advance:**
- coluna+1, except when coluna=NUM_COLUNAS-1: coluna←0 and linha+1.
- linha=NUM_LINHAS-1 wraps to 0 (circular). A burst longer than NUM_LINHAS·NUM_COLUNAS revisits addresses.

**dma_busy:** 1 in ESCRITA, LEITURA and FIM.

## Timing
- **Reset values:** state OCIOSO, dma_rdata=0, dma_rvalid=0, dma_done=0, dma_erro=0, dma_busy=0, dma_wready=0, ram_write=0 (with cpu_req=0). Address and count registers are 0.
- **Reset mid-burst:** abort immediately, no further RAM writes. The remaining data is discarded.
- **CPU path:** zero-latency. Loads see ram_saida in the same cycle; stores commit at the next rising edge.
- **DMA write:** each accepted beat commits at the edge ending that cycle. dma_done occurs the cycle after the last beat.
- **DMA read:** dma_rdata/dma_rvalid appear the cycle after the grant. Throughput is 1 word/cycle with dma_rready=1 and cpu_req=0. dma_done occurs the cycle after the final word is consumed.
- **dma_start to first slot:** 1 cycle.
- **Error or zero-length start:** dma_done (and dma_erro if applicable) the cycle after dma_start.
- **Simultaneous CPU and DMA write to the same address:** the CPU write is performed and the DMA beat is stalled. The DMA then writes the same address on a later cycle, so the DMA value ends up stored.

## Test plan
- **Write burst:** dma_write=1, start (0,9), len=4, wvalid=1, no CPU, data A0..A3 → words land at (0,9),(0,10),(1,0),(1,1); wready high 4 cycles; done one cycle later; erro=0.
- **Circular wrap:** read burst from (10,10), len=2 → rdata = word(10,10), then word(0,0); rvalid 2 cycles; done after second consume.
- **CPU priority:** read burst len=3 with cpu_req=1 for 2 cycles mid-burst → CPU load returns correct data; DMA stalls exactly 2 cycles; DMA data order unchanged.
- **Backpressure:** read burst len=3 with rready toggling 1,0,0,1,1 → rdata held stable while rvalid & ~rready; no word skipped or duplicated.
- **Error and zero length:** start at (11,0) → done=erro=1 next cycle, no ram_write; start len=0 → done=1, erro=0 next cycle.
- **Reset abort:** assert reset on the 2nd beat of a len=5 write burst → all outputs at reset values; only beat 1 is committed.
